mult_div_hilo: RTL

// - Multicycle signed MULT/DIV unit that owns the HI and LO registers.
// - Sits upstream of the 8-input 32-bit register-write mux. hi/lo drive two of its

---
 rtl/mdu_pkg.sv | 19 +
 rtl/div_step.sv | 27 ++
 rtl/mult_div_hilo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multicycle MULT/DIV unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned WIDTH_DEF = 32;
  // One iteration per operand bit.
  localparam int unsigned ITER      = WIDTH_DEF;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_unused_msb;

  // Trial subtract; keep the difference only when it does not go negative.
  always_comb begin
    w_shift  = {rem, dividend_bit};
    w_diff   = w_shift - {1'b0, divisor};
    q_bit    = (w_shift >= {1'b0, divisor});
    rem_next = q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end

  // The MSB is always zero after selection since rem < divisor on entry.
  assign w_unused_msb = w_diff[WIDTH] ^ w_shift[WIDTH];

endmodule

// File: rtl/mult_div_hilo.sv
// Multicycle signed MULT/DIV unit owning the HI/LO registers.
module mult_div_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_t             r_state;
  logic [CntW-1:0]    r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  // MULT: {accumulator, multiplier}. DIV: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] r_prod;

  logic               w_accept;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_q_bit;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Start is honoured in IDLE and in the done cycle (back-to-back issue).
  assign w_accept = start && ((r_state == IDLE) || ((r_state == DONE) && r_done));

  // Operand magnitudes; INT_MIN maps to 2^(WIDTH-1), still representable unsigned.
  always_comb begin
    w_mag_a = a[WIDTH-1] ? -a : a;
    w_mag_b = b[WIDTH-1] ? -b : b;
  end

  // Shift-add multiply step: add multiplicand on LSB, shift the pair right.
  always_comb begin
    w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                 {1'b0, (r_prod[0] ? r_mag_a : {WIDTH{1'b0}})};
    w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem          (r_prod[2*WIDTH-1:WIDTH]),
    .dividend_bit (r_prod[WIDTH-1]),
    .divisor      (r_mag_b),
    .rem_next     (w_rem_next),
    .q_bit        (w_q_bit)
  );

  assign w_div_next = {w_rem_next, r_prod[WIDTH-2:0], w_q_bit};

  // Sign correction applied when HI/LO are written.
  always_comb begin
    w_fix_hi = r_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = r_prod[WIDTH-1:0];
    if (r_op == OP_MULT) begin
      if (r_sign_a ^ r_sign_b) begin
        {w_fix_hi, w_fix_lo} = -r_prod;
      end
    end else begin
      if (r_sign_a ^ r_sign_b) begin
        w_fix_lo = -r_prod[WIDTH-1:0];
      end
      if (r_sign_a) begin
        w_fix_hi = -r_prod[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_op       <= OP_MULT;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_prod     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done     <= 1'b0;
          r_div_zero <= 1'b0;
        end
        MULT: begin
          r_prod <= w_mul_next;
          r_cnt  <= r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) r_state <= FIX;
        end
        DIV: begin
          r_prod <= w_div_next;
          r_cnt  <= r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) r_state <= FIX;
        end
        FIX: begin
          r_hi       <= w_fix_hi;
          r_lo       <= w_fix_lo;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_div_zero <= 1'b0;
          r_state    <= DONE;
        end
        DONE: begin
          if (!r_done) begin
            // Divide-by-zero path: one busy cycle, then the done pulse.
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
          end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Accepted start overrides the state update above.
      if (w_accept) begin
        r_op     <= op;
        r_sign_a <= a[WIDTH-1];
        r_sign_b <= b[WIDTH-1];
        r_mag_a  <= w_mag_a;
        r_mag_b  <= w_mag_b;
        r_cnt    <= CntW'(WIDTH);
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
        if (op == OP_MULT) begin
          r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
          r_state <= MULT;
        end else begin
          r_prod  <= {{WIDTH{1'b0}}, w_mag_a};
          r_state <= (b == '0) ? DONE : DIV;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
